// File: rtl/bme280_sequencer.sv
// bme280_sequencer
//   Autonomous BME280 bring-up and polling controller driving the selector/enable
//   interface of an I2C wrapper. Sequence: soft reset, start-up delay, chip-ID
//   read and check, measurement-mode write, then periodic one-byte-per-transaction
//   burst reads of the data registers. Raw ADC words are published atomically
//   together with a one-cycle o_sample_valid strobe.
//
//   Optional feature macro: BME280_HUM_EN
//     defined   : burst reads sel 8..F, o_hum_raw assembled from bytes 6/7
//     undefined : burst reads sel 8..D, o_hum_raw tied to zero
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   i_run          in   level; 1 = run/continue, 0 = stop after current transaction
//   i_i2c_data     in   [7:0] byte from the wrapper data output
//   o_register_sel out  [3:0] selector code (0 outside transactions)
//   o_i2c_en       out  one-cycle transaction launch pulse
//   o_busy         out  high whenever the sequencer is not IDLE
//   o_id_ok        out  chip ID matched (sticky until the next start)
//   o_err          out  chip ID mismatch (sticky until the next start)
//   o_press_raw    out  [19:0] {MSB, LSB, XLSB[7:4]}
//   o_temp_raw     out  [19:0] {MSB, LSB, XLSB[7:4]}
//   o_hum_raw      out  [15:0] {MSB, LSB}
//   o_sample_valid out  one-cycle strobe, raw outputs updated this cycle
module bme280_sequencer #(
  parameter int          SETUP_CYCLES      = 4,
  parameter int          XFER_CYCLES       = 4000,
  parameter int          RESET_WAIT_CYCLES = 200000,
  parameter int          POLL_CYCLES       = 1000000,
  parameter logic [7:0]  CHIP_ID           = 8'h60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_run,
  input  logic [7:0]  i_i2c_data,
  output logic [3:0]  o_register_sel,
  output logic        o_i2c_en,
  output logic        o_busy,
  output logic        o_id_ok,
  output logic        o_err,
  output logic [19:0] o_press_raw,
  output logic [19:0] o_temp_raw,
  output logic [15:0] o_hum_raw,
  output logic        o_sample_valid
);

  function automatic int fmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int P_MAX = fmax(fmax(SETUP_CYCLES, XFER_CYCLES),
                              fmax(RESET_WAIT_CYCLES, POLL_CYCLES));
  localparam int CW    = $clog2(P_MAX) + 1;

  localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] C_XFER  = CW'(XFER_CYCLES - 1);
  localparam logic [CW-1:0] C_RWAIT = CW'(RESET_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] C_POLL  = CW'(POLL_CYCLES - 1);

`ifdef BME280_HUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 6;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NB - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RESET_XFER, S_RESET_WAIT, S_ID_XFER, S_ID_CHECK,
    S_MEAS_XFER, S_BURST, S_COMMIT, S_POLL, S_ERROR
  } state_t;

  typedef enum logic [1:0] {X_SETUP, X_PULSE, X_WAIT, X_CAPTURE} phase_t;

  state_t          r_state, w_state_next;
  phase_t          r_phase, w_phase_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [2:0]      r_burst_idx, w_burst_next;
  logic [7:0]      r_id_byte;
  logic [7:0]      r_shadow [0:NB-1];
  logic            r_id_ok, r_err, r_sample_valid;
  logic [19:0]     r_press_raw, r_temp_raw;
  logic            w_in_xfer, w_capture;
  logic            w_unused_xlsb;

  assign w_in_xfer = (r_state == S_RESET_XFER) || (r_state == S_ID_XFER) ||
                     (r_state == S_MEAS_XFER)  || (r_state == S_BURST);

  // Transaction phases are nested inside the xfer states; the main state only
  // moves on from CAPTURE, so an en/WAIT window is never cut short by i_run.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_burst_next = r_burst_idx;
    w_cnt_next   = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
    w_capture    = 1'b0;
    if (w_in_xfer) begin
      unique case (r_phase)
        X_SETUP: if (r_cnt == '0) begin
          w_phase_next = X_PULSE;
          w_cnt_next   = '0;
        end
        X_PULSE: begin
          w_phase_next = X_WAIT;
          w_cnt_next   = C_XFER;
        end
        X_WAIT: if (r_cnt == '0) w_phase_next = X_CAPTURE;
        X_CAPTURE: begin
          w_capture    = 1'b1;
          w_phase_next = X_SETUP;
          w_cnt_next   = C_SETUP;
          if (!i_run) begin
            w_state_next = S_IDLE;
          end else begin
            case (r_state)
              S_RESET_XFER: begin
                w_state_next = S_RESET_WAIT;
                w_cnt_next   = C_RWAIT;
              end
              S_ID_XFER:   w_state_next = S_ID_CHECK;
              S_MEAS_XFER: begin
                w_state_next = S_BURST;
                w_burst_next = '0;
              end
              default: begin
                if (r_burst_idx == LAST_IDX) w_state_next = S_COMMIT;
                else                         w_burst_next = r_burst_idx + 3'd1;
              end
            endcase
          end
        end
        default: w_phase_next = X_SETUP;
      endcase
    end else begin
      case (r_state)
        S_IDLE: if (i_run) begin
          w_state_next = S_RESET_XFER;
          w_phase_next = X_SETUP;
          w_cnt_next   = C_SETUP;
        end
        S_RESET_WAIT: begin
          if (!i_run) begin
            w_state_next = S_IDLE;
          end else if (r_cnt == '0) begin
            w_state_next = S_ID_XFER;
            w_phase_next = X_SETUP;
            w_cnt_next   = C_SETUP;
          end
        end
        S_ID_CHECK: begin
          if (!i_run) begin
            w_state_next = S_IDLE;
          end else if (r_id_byte == CHIP_ID) begin
            w_state_next = S_MEAS_XFER;
            w_phase_next = X_SETUP;
            w_cnt_next   = C_SETUP;
          end else begin
            w_state_next = S_ERROR;
          end
        end
        S_COMMIT: begin
          w_state_next = i_run ? S_POLL : S_IDLE;
          w_cnt_next   = C_POLL;
        end
        S_POLL: begin
          if (!i_run) begin
            w_state_next = S_IDLE;
          end else if (r_cnt == '0) begin
            w_state_next = S_BURST;
            w_phase_next = X_SETUP;
            w_cnt_next   = C_SETUP;
            w_burst_next = '0;
          end
        end
        S_ERROR: if (!i_run) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_phase        <= X_SETUP;
      r_cnt          <= '0;
      r_burst_idx    <= '0;
      r_id_byte      <= '0;
      r_id_ok        <= 1'b0;
      r_err          <= 1'b0;
      r_sample_valid <= 1'b0;
      r_press_raw    <= '0;
      r_temp_raw     <= '0;
      for (int i = 0; i < NB; i++) r_shadow[i] <= '0;
    end else begin
      r_state        <= w_state_next;
      r_phase        <= w_phase_next;
      r_cnt          <= w_cnt_next;
      r_burst_idx    <= w_burst_next;
      r_sample_valid <= (r_state == S_COMMIT);
      if (w_capture) begin
        r_id_byte <= i_i2c_data;
        if (r_state == S_BURST) r_shadow[r_burst_idx] <= i_i2c_data;
      end
      // Status flags survive in IDLE and are cleared only on a fresh start.
      if (r_state == S_IDLE && w_state_next != S_IDLE) begin
        r_id_ok <= 1'b0;
        r_err   <= 1'b0;
      end else if (r_state == S_ID_CHECK && w_state_next == S_MEAS_XFER) begin
        r_id_ok <= 1'b1;
      end else if (r_state == S_ID_CHECK && w_state_next == S_ERROR) begin
        r_err <= 1'b1;
      end
      if (r_state == S_COMMIT) begin
        r_press_raw <= {r_shadow[0], r_shadow[1], r_shadow[2][7:4]};
        r_temp_raw  <= {r_shadow[3], r_shadow[4], r_shadow[5][7:4]};
      end
    end
  end

`ifdef BME280_HUM_EN
  logic [15:0] r_hum_raw;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_hum_raw <= '0;
    else if (r_state == S_COMMIT)  r_hum_raw <= {r_shadow[6], r_shadow[7]};
  end
  assign o_hum_raw = r_hum_raw;
`else
  assign o_hum_raw = 16'h0000;
`endif

  // XLSB low nibbles carry no data in this configuration.
  assign w_unused_xlsb = ^{r_shadow[2][3:0], r_shadow[5][3:0]};

  always_comb begin
    o_register_sel = 4'h0;
    case (r_state)
      S_RESET_XFER: o_register_sel = 4'h7;
      S_ID_XFER:    o_register_sel = 4'h1;
      S_MEAS_XFER:  o_register_sel = 4'h5;
      S_BURST:      o_register_sel = {1'b1, r_burst_idx};
      default:      o_register_sel = 4'h0;
    endcase
  end

  assign o_i2c_en       = w_in_xfer && (r_phase == X_PULSE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_id_ok        = r_id_ok;
  assign o_err          = r_err;
  assign o_press_raw    = r_press_raw;
  assign o_temp_raw     = r_temp_raw;
  assign o_sample_valid = r_sample_valid;

endmodule
